// File: rtl/ethernet_to_book_top.sv
// Parses a nibble-wide Ethernet/IPv4/UDP/MoldUDP64 receive stream of ITCH Add/Delete/Execute
// messages, reports each decoded message, and keeps a sorted buy-side price-level book.
module ethernet_to_book_top #(
    parameter logic [47:0] DEVICE_MAC    = 48'h0,
    parameter logic [15:0] UDP_DEST_PORT = 16'd0,
    parameter logic [63:0] STOCK         = "AAPL    ",
    parameter int unsigned BOOK_DEPTH    = 5,
    parameter int unsigned LOCK_DELAY    = 16
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [3:0]  rxDataIn,
    input  logic        rxCtrlIn,
    input  logic        rxClkIn,
    output logic [3:0]  txDataOut,
    output logic        txCtrlOut,
    output logic        txClkOut,
    output logic [73:0] orderDataOut,
    output logic [64:0] refDataOut,
    output logic [63:0] topBuyOut,
    input  logic        intBIn,
    output logic        phyRstBOut,
    output logic        lockedOut
);
    localparam int unsigned IDX_W = (BOOK_DEPTH > 1) ? $clog2(BOOK_DEPTH) : 1;

    typedef enum logic [3:0] {
        StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StMoldHdr, StMoldLen, StMsg, StDrop
    } state_t;

    state_t      r_state, w_state_d, w_hdr_next;
    logic [5:0]  r_cnt, w_cnt_d, w_hdr_last, w_msg_last;
    logic        r_bad, w_bad_d, w_hdr_bad, w_emit;
    logic        r_phase;
    logic [3:0]  r_low;
    logic [7:0]  w_byte, w_mac_byte;
    logic        w_byte_vld, w_msg_byte;
    logic        r_phy, r_locked;
    logic [15:0] r_lock_cnt;

    logic [7:0]  r_type;
    logic [63:0] r_ref, r_stock;
    logic [31:0] r_shares, r_price, w_price_full;
    logic        r_bs_buy, w_is_add, w_is_del, w_is_exec;

    logic        r_ord_valid, r_ord_bs, r_ref_valid;
    logic [7:0]  r_ord_type;
    logic [31:0] r_ord_shares, r_ord_price;
    logic [63:0] r_ref_num;

    logic        r_upd_valid;
    logic [31:0] r_upd_price, r_upd_shares;

    logic [31:0]           r_lvl_price [BOOK_DEPTH];
    logic [31:0]           r_lvl_qty   [BOOK_DEPTH];
    logic [BOOK_DEPTH-1:0] r_lvl_vld;
    logic [31:0]           w_lvl_price [BOOK_DEPTH];
    logic [31:0]           w_lvl_qty   [BOOK_DEPTH];
    logic [BOOK_DEPTH-1:0] w_lvl_vld;
    logic                  w_hit, w_ins;
    logic [IDX_W-1:0]      w_hit_idx, w_ins_idx;

    logic w_unused;
    assign w_unused = ^{rxClkIn, intBIn};

    assign txDataOut    = 4'h0;
    assign txCtrlOut    = 1'b0;
    assign txClkOut     = 1'b0;
    assign phyRstBOut   = r_phy;
    assign lockedOut    = r_locked;
    assign orderDataOut = {r_ord_valid, r_ord_type, r_ord_bs, r_ord_shares, r_ord_price};
    assign refDataOut   = {r_ref_valid, r_ref_num};
    assign topBuyOut    = r_lvl_vld[0] ? {r_lvl_price[0], r_lvl_qty[0]} : 64'h0;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_phy      <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_phy <= 1'b1;
            if (!r_locked) begin
                r_lock_cnt <= r_lock_cnt + 16'd1;
                if (r_lock_cnt == 16'(LOCK_DELAY - 1)) r_locked <= 1'b1;
            end
        end
    end

    // Low nibble arrives first; the byte is complete while the high nibble is on the pins.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_phase <= 1'b0;
            r_low   <= '0;
        end else if (!rxCtrlIn) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) r_low <= rxDataIn;
        end
    end

    assign w_byte     = {rxDataIn, r_low};
    assign w_byte_vld = rxCtrlIn & r_phase;
    assign w_msg_byte = (r_state == StMsg) && w_byte_vld;
    assign w_is_add   = (r_type == 8'h41);
    assign w_is_del   = (r_type == 8'h44);
    assign w_is_exec  = (r_type == 8'h45);
    assign w_price_full = {r_price[23:0], w_byte};

    always_comb begin
        w_hdr_last = 6'd0;
        w_hdr_next = StDrop;
        w_hdr_bad  = 1'b0;
        w_mac_byte = 8'h0;
        for (int i = 0; i < 6; i++) begin
            if (r_cnt == 6'(i)) w_mac_byte = DEVICE_MAC[47-8*i -: 8];
        end
        case (r_state)
            StEthHdr: begin
                w_hdr_last = 6'd13;
                w_hdr_next = StIpHdr;
                if (r_cnt < 6'd6 && w_byte != w_mac_byte) w_hdr_bad = 1'b1;
                if (r_cnt == 6'd12 && w_byte != 8'h08)    w_hdr_bad = 1'b1;
                if (r_cnt == 6'd13 && w_byte != 8'h00)    w_hdr_bad = 1'b1;
            end
            StIpHdr: begin
                w_hdr_last = 6'd19;
                w_hdr_next = StUdpHdr;
                if (r_cnt == 6'd0 && w_byte != 8'h45) w_hdr_bad = 1'b1;
                if (r_cnt == 6'd9 && w_byte != 8'h11) w_hdr_bad = 1'b1;
            end
            StUdpHdr: begin
                w_hdr_last = 6'd7;
                w_hdr_next = StMoldHdr;
                if (r_cnt == 6'd2 && w_byte != UDP_DEST_PORT[15:8]) w_hdr_bad = 1'b1;
                if (r_cnt == 6'd3 && w_byte != UDP_DEST_PORT[7:0])  w_hdr_bad = 1'b1;
            end
            StMoldHdr: begin
                w_hdr_last = 6'd19;
                w_hdr_next = StMoldLen;
            end
            StMoldLen: begin
                w_hdr_last = 6'd1;
                w_hdr_next = StMsg;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_type)
            8'h41:   w_msg_last = 6'd35;
            8'h44:   w_msg_last = 6'd18;
            default: w_msg_last = 6'd30;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bad_d   = r_bad;
        w_emit    = 1'b0;
        if (!rxCtrlIn) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_bad_d   = 1'b0;
        end else begin
            case (r_state)
                StIdle: if (r_locked) w_state_d = StPreamble;
                StPreamble: if (w_byte_vld) begin
                    if (w_byte == 8'hD5)      w_state_d = StEthHdr;
                    else if (w_byte != 8'h55) w_state_d = StDrop;
                end
                StEthHdr, StIpHdr, StUdpHdr, StMoldHdr, StMoldLen: if (w_byte_vld) begin
                    if (r_cnt == w_hdr_last) begin
                        w_cnt_d   = '0;
                        w_bad_d   = 1'b0;
                        w_state_d = (r_bad || w_hdr_bad) ? StDrop : w_hdr_next;
                    end else begin
                        w_cnt_d = r_cnt + 6'd1;
                        w_bad_d = r_bad | w_hdr_bad;
                    end
                end
                StMsg: if (w_byte_vld) begin
                    if (r_cnt == 6'd0) begin
                        if (w_byte == 8'h41 || w_byte == 8'h44 || w_byte == 8'h45) begin
                            w_cnt_d = 6'd1;
                        end else begin
                            w_state_d = StDrop;
                        end
                    end else if (r_cnt == w_msg_last) begin
                        w_emit  = 1'b1;
                        w_cnt_d = '0;
                    end else begin
                        w_cnt_d = r_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bad   <= w_bad_d;
        end
    end

    // Field capture by byte offset; the final byte of a message is merged combinationally.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_type       <= '0;
            r_ref        <= '0;
            r_stock      <= '0;
            r_shares     <= '0;
            r_price      <= '0;
            r_bs_buy     <= 1'b0;
            r_ord_valid  <= 1'b0;
            r_ord_type   <= '0;
            r_ord_bs     <= 1'b0;
            r_ord_shares <= '0;
            r_ord_price  <= '0;
            r_ref_valid  <= 1'b0;
            r_ref_num    <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_price  <= '0;
            r_upd_shares <= '0;
        end else begin
            r_ord_valid <= w_emit;
            r_ref_valid <= w_emit;
            r_upd_valid <= w_emit && w_is_add && r_bs_buy && (r_stock == STOCK);
            if (w_msg_byte) begin
                if (r_cnt == 6'd0) r_type <= w_byte;
                if (r_cnt >= 6'd11 && r_cnt <= 6'd18) r_ref <= {r_ref[55:0], w_byte};
                if (w_is_add) begin
                    if (r_cnt == 6'd19) r_bs_buy <= (w_byte == 8'h42);
                    if (r_cnt >= 6'd20 && r_cnt <= 6'd23) r_shares <= {r_shares[23:0], w_byte};
                    if (r_cnt >= 6'd24 && r_cnt <= 6'd31) r_stock <= {r_stock[55:0], w_byte};
                    if (r_cnt >= 6'd32 && r_cnt <= 6'd35) r_price <= w_price_full;
                end
                if (w_is_exec && r_cnt >= 6'd19 && r_cnt <= 6'd22) begin
                    r_shares <= {r_shares[23:0], w_byte};
                end
            end
            if (w_emit) begin
                r_ord_type   <= r_type;
                r_ord_bs     <= w_is_add & r_bs_buy;
                r_ord_shares <= w_is_del ? 32'h0 : r_shares;
                r_ord_price  <= w_is_add ? w_price_full : 32'h0;
                r_ref_num    <= w_is_del ? {r_ref[55:0], w_byte} : r_ref;
                r_upd_price  <= w_price_full;
                r_upd_shares <= r_shares;
            end
        end
    end

    // Levels are contiguous from index 0, so the first empty or lower-priced slot is the
    // insertion point whether the book is partially filled or full.
    always_comb begin
        w_lvl_price = r_lvl_price;
        w_lvl_qty   = r_lvl_qty;
        w_lvl_vld   = r_lvl_vld;
        w_hit       = 1'b0;
        w_ins       = 1'b0;
        w_hit_idx   = '0;
        w_ins_idx   = '0;
        for (int i = BOOK_DEPTH - 1; i >= 0; i--) begin
            if (r_lvl_vld[i] && r_lvl_price[i] == r_upd_price) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_lvl_vld[i] || r_lvl_price[i] < r_upd_price) begin
                w_ins     = 1'b1;
                w_ins_idx = IDX_W'(i);
            end
        end
        if (w_hit) begin
            w_lvl_qty[w_hit_idx] = r_lvl_qty[w_hit_idx] + r_upd_shares;
        end else if (w_ins) begin
            for (int j = 1; j < BOOK_DEPTH; j++) begin
                if (IDX_W'(j) > w_ins_idx) begin
                    w_lvl_price[j] = r_lvl_price[j-1];
                    w_lvl_qty[j]   = r_lvl_qty[j-1];
                    w_lvl_vld[j]   = r_lvl_vld[j-1];
                end
            end
            w_lvl_price[w_ins_idx] = r_upd_price;
            w_lvl_qty[w_ins_idx]   = r_upd_shares;
            w_lvl_vld[w_ins_idx]   = 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_lvl_vld <= '0;
            for (int i = 0; i < BOOK_DEPTH; i++) begin
                r_lvl_price[i] <= '0;
                r_lvl_qty[i]   <= '0;
            end
        end else if (r_upd_valid) begin
            r_lvl_vld   <= w_lvl_vld;
            r_lvl_price <= w_lvl_price;
            r_lvl_qty   <= w_lvl_qty;
        end
    end

endmodule

// File: tb/tb_ethernet_to_book_top.sv
// Directed bench for ethernet_to_book_top: builds byte-level frames, drives them as nibbles
// and checks decoded message pulses and top-of-book against hand-computed values.
module tb_ethernet_to_book_top;
    localparam logic [47:0] MAC  = 48'h0A0B0C0D0E0F;
    localparam logic [15:0] PORT = 16'h3039;
    localparam logic [63:0] AAPL = "AAPL    ";
    localparam logic [63:0] MSFT = "MSFT    ";
    localparam int          LOCK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rx_data = 4'h0;
    logic        rx_ctrl = 1'b0;
    logic        rx_clk = 1'b0;
    logic        int_b = 1'b1;
    logic [3:0]  tx_data;
    logic        tx_ctrl, tx_clk, phy_rst_b, locked;
    logic [73:0] order_data;
    logic [64:0] ref_data;
    logic [63:0] top_buy;

    int          vecs = 0;
    int          miss = 0;
    int          n_ord = 0;
    int          n_ref = 0;
    logic [73:0] last_ord = '0;
    logic [63:0] last_ref = '0;
    logic [7:0]  frame_q[$];

    ethernet_to_book_top #(
        .DEVICE_MAC    (MAC),
        .UDP_DEST_PORT (PORT),
        .STOCK         (AAPL),
        .BOOK_DEPTH    (5),
        .LOCK_DELAY    (LOCK)
    ) dut (
        .clkIn        (clk),
        .rstIn        (rst),
        .rxDataIn     (rx_data),
        .rxCtrlIn     (rx_ctrl),
        .rxClkIn      (rx_clk),
        .txDataOut    (tx_data),
        .txCtrlOut    (tx_ctrl),
        .txClkOut     (tx_clk),
        .orderDataOut (order_data),
        .refDataOut   (ref_data),
        .topBuyOut    (top_buy),
        .intBIn       (int_b),
        .phyRstBOut   (phy_rst_b),
        .lockedOut    (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (order_data[73]) begin
            n_ord    <= n_ord + 1;
            last_ord <= order_data;
        end
        if (ref_data[64]) begin
            n_ref    <= n_ref + 1;
            last_ref <= ref_data[63:0];
        end
    end

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frame_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic push_hdr(input logic [47:0] mac, input logic [15:0] port);
        frame_q.delete();
        repeat (7) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        push_be(64'(mac), 6);
        push_be(64'h0000_0011_2233_4455, 6);
        push_be(64'h0800, 2);
        frame_q.push_back(8'h45);
        repeat (8) frame_q.push_back(8'h00);
        frame_q.push_back(8'h11);
        repeat (10) frame_q.push_back(8'h00);
        push_be(64'h1234, 2);
        push_be(64'(port), 2);
        push_be(64'h0, 4);
        repeat (22) frame_q.push_back(8'h00);
    endtask

    task automatic push_add(input logic [63:0] refn, input logic [7:0] bs,
                            input logic [31:0] shares, input logic [63:0] stock,
                            input logic [31:0] price);
        frame_q.push_back(8'h41);
        repeat (10) frame_q.push_back(8'h00);
        push_be(refn, 8);
        frame_q.push_back(bs);
        push_be(64'(shares), 4);
        push_be(stock, 8);
        push_be(64'(price), 4);
    endtask

    task automatic push_del(input logic [63:0] refn);
        frame_q.push_back(8'h44);
        repeat (10) frame_q.push_back(8'h00);
        push_be(refn, 8);
    endtask

    task automatic push_exec(input logic [63:0] refn, input logic [31:0] shares);
        frame_q.push_back(8'h45);
        repeat (10) frame_q.push_back(8'h00);
        push_be(refn, 8);
        push_be(64'(shares), 4);
        push_be(64'h0102_0304_0506_0708, 8);
    endtask

    task automatic drive_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_ctrl = 1'b1;
            rx_data = frame_q[i][3:0];
            @(negedge clk);
            rx_data = frame_q[i][7:4];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        rx_ctrl = 1'b0;
        rx_data = 4'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame();
        drive_bytes(frame_q.size());
        end_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_ctrl = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (order_data !== 74'h0 || ref_data !== 65'h0 || top_buy !== 64'h0) begin
            miss++;
            $display("FAIL reset_outputs: got %h/%h/%h required all zero",
                     order_data, ref_data, top_buy);
        end
        vecs++;
        if ({phy_rst_b, locked, tx_data, tx_ctrl, tx_clk} !== 8'h0) begin
            miss++;
            $display("FAIL reset_ctrl: got phy=%b locked=%b tx=%h/%b/%b required all zero",
                     phy_rst_b, locked, tx_data, tx_ctrl, tx_clk);
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (phy_rst_b !== 1'b1) begin
            miss++;
            $display("FAIL phy_release: got %b required 1", phy_rst_b);
        end
        repeat (LOCK - 2) @(negedge clk);
        vecs++;
        if (locked !== 1'b0) begin
            miss++;
            $display("FAIL lock_early: got %b required 0 after %0d cycles", locked, LOCK - 1);
        end
        @(negedge clk);
        vecs++;
        if (locked !== 1'b1) begin
            miss++;
            $display("FAIL lock_on_time: got %b required 1 after %0d cycles", locked, LOCK);
        end
    endtask

    task automatic test_first_add();
        int b_ord;
        b_ord = n_ord;
        push_hdr(MAC, PORT);
        push_add(64'h1111, 8'h42, 32'h45, AAPL, 32'h0022FEFC);
        drive_bytes(frame_q.size());
        @(negedge clk);
        rx_ctrl = 1'b0;
        rx_data = 4'h0;
        vecs++;
        if (order_data !== {1'b1, 8'h41, 1'b1, 32'h45, 32'h0022FEFC}) begin
            miss++;
            $display("FAIL first_add_order: got %h required %h", order_data,
                     {1'b1, 8'h41, 1'b1, 32'h45, 32'h0022FEFC});
        end
        vecs++;
        if (ref_data !== {1'b1, 64'h1111}) begin
            miss++;
            $display("FAIL first_add_ref: got %h required %h", ref_data, {1'b1, 64'h1111});
        end
        vecs++;
        if (top_buy !== 64'h0) begin
            miss++;
            $display("FAIL top_latency_early: got %h required 0", top_buy);
        end
        @(negedge clk);
        vecs++;
        if (order_data[73] !== 1'b0 || ref_data !== {1'b0, 64'h1111}) begin
            miss++;
            $display("FAIL pulse_width: got ord_v=%b ref=%h required 0/%h",
                     order_data[73], ref_data, {1'b0, 64'h1111});
        end
        vecs++;
        if (top_buy !== {32'h0022FEFC, 32'h45}) begin
            miss++;
            $display("FAIL first_add_top: got %h required %h", top_buy, {32'h0022FEFC, 32'h45});
        end
        repeat (3) @(negedge clk);
        vecs++;
        if (n_ord - b_ord !== 1) begin
            miss++;
            $display("FAIL first_add_count: got %0d required 1", n_ord - b_ord);
        end
    endtask

    task automatic test_accumulate();
        push_hdr(MAC, PORT);
        push_add(64'h2222, 8'h42, 32'h555, AAPL, 32'h0022FEFC);
        send_frame();
        vecs++;
        if (top_buy !== {32'h0022FEFC, 32'h59A}) begin
            miss++;
            $display("FAIL accumulate: got %h required %h", top_buy, {32'h0022FEFC, 32'h59A});
        end
    endtask

    task automatic test_back_to_back();
        int b_ord;
        b_ord = n_ord;
        push_hdr(MAC, PORT);
        push_add(64'h3001, 8'h42, 32'h10, AAPL, 32'h00224000);
        push_add(64'h3002, 8'h42, 32'h20, AAPL, 32'h00223000);
        push_add(64'h3003, 8'h42, 32'h30, AAPL, 32'h00222000);
        push_add(64'h3004, 8'h42, 32'h40, AAPL, 32'h00221000);
        send_frame();
        vecs++;
        if (n_ord - b_ord !== 4 || last_ref !== 64'h3004) begin
            miss++;
            $display("FAIL back_to_back: got %0d pulses last ref %h required 4 / 3004",
                     n_ord - b_ord, last_ref);
        end
        vecs++;
        if (top_buy !== {32'h0022FEFC, 32'h59A}) begin
            miss++;
            $display("FAIL fill_top: got %h required %h", top_buy, {32'h0022FEFC, 32'h59A});
        end
        push_hdr(MAC, PORT);
        push_add(64'h3005, 8'h42, 32'h50, AAPL, 32'h00220000);
        send_frame();
        vecs++;
        if (top_buy !== {32'h0022FEFC, 32'h59A}) begin
            miss++;
            $display("FAIL full_discard: got %h required %h", top_buy, {32'h0022FEFC, 32'h59A});
        end
        push_hdr(MAC, PORT);
        push_add(64'h3006, 8'h42, 32'h7, AAPL, 32'h00230000);
        send_frame();
        vecs++;
        if (top_buy !== {32'h00230000, 32'h7}) begin
            miss++;
            $display("FAIL insert_top: got %h required %h", top_buy, {32'h00230000, 32'h7});
        end
    endtask

    task automatic test_filters();
        int b_ord;
        push_hdr(MAC, PORT);
        push_add(64'h4001, 8'h53, 32'h11, AAPL, 32'h00300000);
        send_frame();
        vecs++;
        if (last_ord !== {1'b1, 8'h41, 1'b0, 32'h11, 32'h00300000}
            || top_buy !== {32'h00230000, 32'h7}) begin
            miss++;
            $display("FAIL sell_add: got ord %h top %h required %h / %h", last_ord, top_buy,
                     {1'b1, 8'h41, 1'b0, 32'h11, 32'h00300000}, {32'h00230000, 32'h7});
        end
        b_ord = n_ord;
        push_hdr(MAC, PORT);
        push_add(64'h4002, 8'h42, 32'h12, MSFT, 32'h00310000);
        frame_q.push_back(8'h5A);
        push_add(64'h4003, 8'h42, 32'h13, AAPL, 32'h00320000);
        send_frame();
        vecs++;
        if (n_ord - b_ord !== 1 || last_ord !== {1'b1, 8'h41, 1'b1, 32'h12, 32'h00310000}) begin
            miss++;
            $display("FAIL other_stock_unknown: got %0d pulses ord %h required 1 / %h",
                     n_ord - b_ord, last_ord, {1'b1, 8'h41, 1'b1, 32'h12, 32'h00310000});
        end
        vecs++;
        if (top_buy !== {32'h00230000, 32'h7}) begin
            miss++;
            $display("FAIL filter_book: got %h required %h", top_buy, {32'h00230000, 32'h7});
        end
    endtask

    task automatic test_bad_headers();
        int b_ord;
        int b_ref;
        for (int k = 0; k < 3; k++) begin
            b_ord = n_ord;
            b_ref = n_ref;
            push_hdr((k == 0) ? 48'h0A0B0C0D0E10 : MAC, (k == 1) ? 16'h303A : PORT);
            if (k == 2) frame_q[31] = 8'h06;
            push_add(64'h5000, 8'h42, 32'h99, AAPL, 32'h00500000);
            send_frame();
            vecs++;
            if (n_ord - b_ord !== 0 || n_ref - b_ref !== 0
                || top_buy !== {32'h00230000, 32'h7}) begin
                miss++;
                $display("FAIL bad_header_%0d: got %0d/%0d pulses top %h required 0/0 %h",
                         k, n_ord - b_ord, n_ref - b_ref, top_buy, {32'h00230000, 32'h7});
            end
        end
    endtask

    task automatic test_delete_execute();
        push_hdr(MAC, PORT);
        push_del(64'hDEF12373DEFDE89C);
        send_frame();
        vecs++;
        if (last_ref !== 64'hDEF12373DEFDE89C || last_ord !== {1'b1, 8'h44, 65'h0}) begin
            miss++;
            $display("FAIL delete: got ref %h ord %h required DEF12373DEFDE89C / %h",
                     last_ref, last_ord, {1'b1, 8'h44, 65'h0});
        end
        vecs++;
        if (top_buy !== {32'h00230000, 32'h7}) begin
            miss++;
            $display("FAIL delete_book: got %h required %h", top_buy, {32'h00230000, 32'h7});
        end
        push_hdr(MAC, PORT);
        push_exec(64'h00000000CAFEF00D, 32'h100);
        send_frame();
        vecs++;
        if (last_ref !== 64'h00000000CAFEF00D
            || last_ord !== {1'b1, 8'h45, 1'b0, 32'h100, 32'h0}) begin
            miss++;
            $display("FAIL execute: got ref %h ord %h required CAFEF00D / %h",
                     last_ref, last_ord, {1'b1, 8'h45, 1'b0, 32'h100, 32'h0});
        end
    endtask

    task automatic test_abort();
        int b_ord;
        b_ord = n_ord;
        push_hdr(MAC, PORT);
        push_add(64'h6000, 8'h42, 32'h9, AAPL, 32'h00400000);
        drive_bytes(frame_q.size() - 10);
        end_frame();
        vecs++;
        if (n_ord - b_ord !== 0 || top_buy !== {32'h00230000, 32'h7}) begin
            miss++;
            $display("FAIL abort: got %0d pulses top %h required 0 / %h",
                     n_ord - b_ord, top_buy, {32'h00230000, 32'h7});
        end
        send_frame();
        vecs++;
        if (n_ord - b_ord !== 1 || top_buy !== {32'h00400000, 32'h9}) begin
            miss++;
            $display("FAIL after_abort: got %0d pulses top %h required 1 / %h",
                     n_ord - b_ord, top_buy, {32'h00400000, 32'h9});
        end
    endtask

    task automatic test_reset_mid_frame();
        push_hdr(MAC, PORT);
        push_add(64'h7000, 8'h42, 32'h8, AAPL, 32'h00600000);
        drive_bytes(40);
        rst = 1'b1;
        @(negedge clk);
        rx_ctrl = 1'b0;
        rx_data = 4'h0;
        vecs++;
        if (top_buy !== 64'h0 || locked !== 1'b0 || phy_rst_b !== 1'b0) begin
            miss++;
            $display("FAIL mid_reset: got top %h locked %b phy %b required 0/0/0",
                     top_buy, locked, phy_rst_b);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (LOCK + 2) @(negedge clk);
        push_hdr(MAC, PORT);
        push_add(64'h7001, 8'h42, 32'h3, AAPL, 32'h00000011);
        send_frame();
        vecs++;
        if (top_buy !== {32'h00000011, 32'h3}) begin
            miss++;
            $display("FAIL post_reset_book: got %h required %h", top_buy, {32'h00000011, 32'h3});
        end
    endtask

    initial begin
        test_reset();
        test_first_add();
        test_accumulate();
        test_back_to_back();
        test_filters();
        test_bad_headers();
        test_delete_execute();
        test_abort();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/ethernet_to_book_top.md
ETHERNET_TO_BOOK_TOP -- requirements
Module: ethernet_to_book_top

Interface
REQ-001 Parameter DEVICE_MAC, 48'h0 default, destination MAC accepted.
REQ-002 Parameter UDP_DEST_PORT, 16'd0 default, UDP destination port accepted.
REQ-003 Parameter STOCK, 64-bit ASCII "AAPL    " default, only symbol booked.
REQ-004 Parameter BOOK_DEPTH, 5 default, buy-side price levels held.
REQ-005 Parameter LOCK_DELAY, 16 default, cycles from reset release to lockedOut.
REQ-006 clkIn  in  1  sole clock; all logic on rising edge.
REQ-007 rstIn  in  1  reset; synchronous, active-high.
REQ-008 rxDataIn  in  4  receive nibble, sampled on clkIn.
REQ-009 rxCtrlIn  in  1  receive data valid; high for the whole frame.
REQ-010 rxClkIn  in  1  unused; no logic clocked by it.
REQ-011 txDataOut  out  4  constant 0 (no transmit path).
REQ-012 txCtrlOut  out  1  constant 0.
REQ-013 txClkOut  out  1  constant 0.
REQ-014 orderDataOut  out  74  {valid[73], msgType[72:65], buySell[64], shares[63:32], price[31:0]}.
REQ-015 refDataOut  out  65  {valid[64], refNum[63:0]}.
REQ-016 topBuyOut  out  64  {price[63:32], aggregated shares[31:0]}; 0 when book empty.
REQ-017 intBIn  in  1  PHY interrupt; ignored.
REQ-018 phyRstBOut  out  1  active-low PHY reset.
REQ-019 lockedOut  out  1  ready indicator.

Function
REQ-020 Bytes assembled from two consecutive nibbles with rxCtrlIn high, low nibble first; all multi-byte fields big-endian.
REQ-021 States: IDLE, PREAMBLE, ETH_HDR(14B), IP_HDR(20B), UDP_HDR(8B), MOLD_HDR(20B), MOLD_LEN(2B), MSG, DROP.
REQ-022 IDLE->PREAMBLE on rxCtrlIn high while lockedOut high; 0x55 bytes skipped, 0xD5 -> ETH_HDR, any other byte -> DROP.
REQ-023 ETH_HDR: dest MAC != DEVICE_MAC or ethertype != 0x0800 -> DROP at header end.
REQ-024 IP_HDR: byte0 != 0x45 or protocol != 17 -> DROP; checksum not verified.
REQ-025 UDP_HDR: dest port != UDP_DEST_PORT -> DROP; UDP checksum ignored.
REQ-026 MOLD_HDR/MOLD_LEN bytes consumed without checks; then MSG.
REQ-027 MSG: first byte is msgType; length implied: 'A'(0x41)=36B, 'D'(0x44)=19B, 'E'(0x45)=31B; unknown type -> DROP.
REQ-028 Messages back-to-back with no per-message length prefix; after each message return to message start.
REQ-029 Add layout: type1, locate2, track2, timestamp6, refNum8, buySell1('B'/'S'), shares4, stock8, price4.
REQ-030 Delete layout: type1, locate2, track2, timestamp6, refNum8; Execute adds execShares4, matchNum8.
REQ-031 One cycle after last message byte: orderDataOut valid=1 one cycle, refDataOut valid=1 one cycle; delete/execute report shares=execShares (0 for delete), price=0, buySell=0.
REQ-032 Valid bits 0 all other cycles; data fields hold last value.
REQ-033 Book updates only on Add with buySell='B' and stock==STOCK; delete/execute/sell do not modify book.
REQ-034 Book: BOOK_DEPTH levels sorted price descending, prices unique.
REQ-035 Price equal to existing level: shares added (32-bit wrap).
REQ-036 New price above some level: inserted, lower levels shift down, bottom dropped if full.
REQ-037 New price below all levels: appended if not full, else discarded.
REQ-038 topBuyOut reflects level 0 two cycles after last message byte.
REQ-039 rxCtrlIn low anywhere: state -> IDLE, partial message discarded, no valid pulse.
REQ-040 DROP holds until rxCtrlIn low.

Reset
REQ-041 While rstIn high: all outputs 0, phyRstBOut 0, lockedOut 0, book cleared, state IDLE.
REQ-042 After rstIn low: phyRstBOut 1 next cycle; lockedOut 1 after LOCK_DELAY cycles and stays high.
REQ-043 Reset mid-frame aborts frame; book cleared.

Verification
REQ-044 Valid frame, one buy Add AAPL price 0x0022FEFC shares 0x45 -> orderDataOut valid once; topBuyOut={0x0022FEFC,0x00000045}.
REQ-045 Second Add same price shares 0x555 -> topBuyOut={0x0022FEFC,0x0000059A}.
REQ-046 Adds at 0x224000, 0x223000, 0x222000, 0x221000 -> five levels; sixth lower discarded; topBuyOut unchanged.
REQ-047 Wrong dest MAC or UDP port -> no valid pulses, book unchanged.
REQ-048 Delete refNum 0xDEF12373DEFDE89C -> refDataOut valid with that value; book unchanged.
REQ-049 rxCtrlIn dropped mid-Add -> no pulse; next frame parsed normally.
